// File: rtl/irq_source_gen.sv
// Interrupt request generator: three debounced event inputs are queued per line
// and issued to the arbiter as pulses, each acknowledged by the line's wait rise/fall.

module irq_line #(
    parameter int DEBOUNCE    = 16,
    parameter int PULSE_LEN   = 2,
    parameter int GAP         = 4,
    parameter int ACK_TIMEOUT = 64,
    parameter int PEND_W      = 3
) (
    input  logic              clk,
    input  logic              CLR,
    input  logic              evt_raw,
    input  logic              en,
    input  logic              irq_wait,
    input  logic              ovf_clr,
    output logic              ir,
    output logic [PEND_W-1:0] pend_cnt,
    output logic              ovf,
    output logic              busy
);
    localparam int TMAX0 = (PULSE_LEN > GAP) ? PULSE_LEN : GAP;
    localparam int TMAX  = (TMAX0 > ACK_TIMEOUT) ? TMAX0 : ACK_TIMEOUT;
    localparam int TW    = $clog2(TMAX + 1);
    localparam int DW    = $clog2(DEBOUNCE + 1);

    typedef enum logic [2:0] {IDLE, PULSE, WAIT_RISE, WAIT_FALL, HOLD} state_t;

    logic          sync1, sync2, level, evt_pulse;
    logic [DW-1:0] db_cnt;
    state_t        state, state_nxt;
    logic [TW-1:0] tmr, tmr_nxt;
    logic          dec, inc, full, sat;

    always_ff @(posedge clk or posedge CLR) begin
        if (CLR) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            level     <= 1'b0;
            db_cnt    <= '0;
            evt_pulse <= 1'b0;
        end else begin
            sync1     <= evt_raw;
            sync2     <= sync1;
            evt_pulse <= 1'b0;
            if (sync2 == level) begin
                db_cnt <= '0;
            end else if (db_cnt == DW'(DEBOUNCE - 1)) begin
                // evt_pulse is registered together with the flip so latency stays 2+DEBOUNCE
                level     <= sync2;
                db_cnt    <= '0;
                evt_pulse <= sync2;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        tmr_nxt   = tmr;
        dec       = 1'b0;
        if (!en) begin
            state_nxt = IDLE;
            tmr_nxt   = '0;
        end else begin
            case (state)
                IDLE: if (pend_cnt != '0) begin
                    state_nxt = PULSE;
                    tmr_nxt   = TW'(PULSE_LEN);
                end
                PULSE: if (tmr <= TW'(1)) begin
                    state_nxt = WAIT_RISE;
                    tmr_nxt   = '0;
                end else begin
                    tmr_nxt = tmr - 1'b1;
                end
                WAIT_RISE: if (irq_wait) begin
                    state_nxt = WAIT_FALL;
                end else if (tmr == TW'(ACK_TIMEOUT - 1)) begin
                    state_nxt = PULSE;
                    tmr_nxt   = TW'(PULSE_LEN);
                end else begin
                    tmr_nxt = tmr + 1'b1;
                end
                WAIT_FALL: if (!irq_wait) begin
                    state_nxt = HOLD;
                    tmr_nxt   = '0;
                    dec       = 1'b1;
                end
                HOLD: if (tmr == TW'(GAP - 1)) begin
                    state_nxt = IDLE;
                    tmr_nxt   = '0;
                end else begin
                    tmr_nxt = tmr + 1'b1;
                end
                default: begin
                    state_nxt = IDLE;
                    tmr_nxt   = '0;
                end
            endcase
        end
    end

    assign inc  = evt_pulse & en;
    assign full = &pend_cnt;
    assign sat  = inc & ~dec & full;

    always_ff @(posedge clk or posedge CLR) begin
        if (CLR) begin
            state    <= IDLE;
            tmr      <= '0;
            ir       <= 1'b0;
            pend_cnt <= '0;
            ovf      <= 1'b0;
        end else begin
            state <= state_nxt;
            tmr   <= tmr_nxt;
            ir    <= (state_nxt == PULSE);
            if (inc && !dec && !full)
                pend_cnt <= pend_cnt + 1'b1;
            else if (dec && !inc)
                pend_cnt <= pend_cnt - 1'b1;
            if (sat)
                ovf <= 1'b1;
            else if (ovf_clr)
                ovf <= 1'b0;
        end
    end

    assign busy = (state != IDLE) || (pend_cnt != '0);
endmodule

module irq_source_gen #(
    parameter int DEBOUNCE    = 16,
    parameter int PULSE_LEN   = 2,
    parameter int GAP         = 4,
    parameter int ACK_TIMEOUT = 64,
    parameter int PEND_W      = 3
) (
    input  logic                clk,
    input  logic                CLR,
    input  logic [2:0]          evt_raw,
    input  logic [2:0]          en,
    input  logic [2:0]          irq_wait,
    input  logic [2:0]          ovf_clr,
    output logic [2:0]          ir,
    output logic [3*PEND_W-1:0] pend_cnt,
    output logic [2:0]          ovf,
    output logic                busy
);
    logic [2:0] line_busy;

    for (genvar n = 0; n < 3; n++) begin : g_line
        irq_line #(
            .DEBOUNCE(DEBOUNCE), .PULSE_LEN(PULSE_LEN), .GAP(GAP),
            .ACK_TIMEOUT(ACK_TIMEOUT), .PEND_W(PEND_W)
        ) u_line (
            .clk     (clk),
            .CLR     (CLR),
            .evt_raw (evt_raw[n]),
            .en      (en[n]),
            .irq_wait(irq_wait[n]),
            .ovf_clr (ovf_clr[n]),
            .ir      (ir[n]),
            .pend_cnt(pend_cnt[n*PEND_W +: PEND_W]),
            .ovf     (ovf[n]),
            .busy    (line_busy[n])
        );
    end

    assign busy = |line_busy;
endmodule

// File: tb/tb_irq_source_gen.sv
// Bench for irq_source_gen: table-driven issue sequence, hand-written corner cases,
// and a random run compared every cycle against a behavioural model.

module tb_irq_source_gen;
    localparam int DEB = 4, PL = 2, GAP = 4, ATO = 64, PW = 3;
    localparam int PMAX = (1 << PW) - 1;
    localparam int M_IDLE = 0, M_PULSE = 1, M_RISE = 2, M_FALL = 3, M_HOLD = 4;

    logic          clk = 1'b0;
    logic          CLR;
    logic [2:0]    evt_raw, en, irq_wait, ovf_clr;
    logic [2:0]    ir, ovf, ir_prev;
    logic [3*PW-1:0] pend_cnt;
    logic          busy;
    wire  [15:0]   dut_out = {ir, pend_cnt, ovf, busy};

    int n_tests = 0, n_fail = 0;

    // behavioural model: elapsed-time counters per line
    int m_s1[3], m_s2[3], m_lvl[3], m_run[3], m_evt[3];
    int m_pend[3], m_ovf[3], m_mode[3], m_t[3];

    irq_source_gen #(.DEBOUNCE(DEB), .PULSE_LEN(PL), .GAP(GAP), .ACK_TIMEOUT(ATO), .PEND_W(PW)) dut (
        .clk(clk), .CLR(CLR), .evt_raw(evt_raw), .en(en), .irq_wait(irq_wait),
        .ovf_clr(ovf_clr), .ir(ir), .pend_cnt(pend_cnt), .ovf(ovf), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int n = 0; n < 3; n++) begin
            m_s1[n] = 0; m_s2[n] = 0; m_lvl[n] = 0; m_run[n] = 0; m_evt[n] = 0;
            m_pend[n] = 0; m_ovf[n] = 0; m_mode[n] = M_IDLE; m_t[n] = 0;
        end
    endtask

    task automatic model_step();
        for (int n = 0; n < 3; n++) begin
            int inc, dec, nevt;
            bit e, w;
            e = en[n]; w = irq_wait[n];
            inc = (m_evt[n] != 0 && e) ? 1 : 0;
            dec = (m_mode[n] == M_FALL && !w && e) ? 1 : 0;
            if (!e) begin
                m_mode[n] = M_IDLE; m_t[n] = 0;
            end else begin
                case (m_mode[n])
                    M_IDLE:  if (m_pend[n] != 0) begin m_mode[n] = M_PULSE; m_t[n] = 1; end
                    M_PULSE: if (m_t[n] == PL) begin m_mode[n] = M_RISE; m_t[n] = 1; end
                             else m_t[n]++;
                    M_RISE:  if (w) m_mode[n] = M_FALL;
                             else if (m_t[n] == ATO) begin m_mode[n] = M_PULSE; m_t[n] = 1; end
                             else m_t[n]++;
                    M_FALL:  if (!w) begin m_mode[n] = M_HOLD; m_t[n] = 1; end
                    default: if (m_t[n] == GAP) begin m_mode[n] = M_IDLE; m_t[n] = 0; end
                             else m_t[n]++;
                endcase
            end
            if (inc && !dec && m_pend[n] == PMAX) m_ovf[n] = 1;
            else if (ovf_clr[n]) m_ovf[n] = 0;
            if (inc && !dec && m_pend[n] < PMAX) m_pend[n]++;
            else if (dec && !inc) m_pend[n]--;
            nevt = 0;
            if (m_s2[n] != m_lvl[n]) begin
                if (m_run[n] == DEB - 1) begin
                    m_lvl[n] = m_s2[n]; m_run[n] = 0; nevt = m_s2[n];
                end else m_run[n]++;
            end else m_run[n] = 0;
            m_evt[n] = nevt;
            m_s2[n] = m_s1[n];
            m_s1[n] = evt_raw[n];
        end
    endtask

    function automatic logic [15:0] model_out();
        logic [2:0] i, o;
        logic [3*PW-1:0] p;
        logic b;
        b = 1'b0;
        for (int n = 0; n < 3; n++) begin
            i[n] = (m_mode[n] == M_PULSE);
            o[n] = (m_ovf[n] != 0);
            p[n*PW +: PW] = PW'(m_pend[n]);
            b = b | (m_mode[n] != M_IDLE) | (m_pend[n] != 0);
        end
        return {i, p, o, b};
    endfunction

    task automatic tick();
        ir_prev = ir;
        model_step();
        @(posedge clk);
        #1;
        check("model", dut_out, model_out());
    endtask

    task automatic do_reset();
        evt_raw = '0; en = 3'b111; irq_wait = '0; ovf_clr = '0;
        CLR = 1'b1;
        @(posedge clk);
        #1;
        check("reset_state", dut_out, 16'h0);
        model_reset();
        CLR = 1'b0;
    endtask

    function automatic logic [15:0] pk(input logic [2:0] i, input int p0, input logic b);
        return {i, 6'b0, 3'(p0), 3'b0, b};
    endfunction

    typedef struct {
        logic [2:0]  evt;
        logic [2:0]  wt;
        int          cyc;
        logic [15:0] exp;
    } vec_t;

    vec_t vt[10];

    initial begin
        int rises, pmax, per;
        bit found;

        vt[0] = '{3'b001, 3'b000, 6,  pk(3'b000, 0, 1'b0)};
        vt[1] = '{3'b001, 3'b000, 1,  pk(3'b000, 1, 1'b1)};
        vt[2] = '{3'b001, 3'b000, 1,  pk(3'b001, 1, 1'b1)};
        vt[3] = '{3'b001, 3'b000, 1,  pk(3'b001, 1, 1'b1)};
        vt[4] = '{3'b001, 3'b000, 1,  pk(3'b000, 1, 1'b1)};
        vt[5] = '{3'b001, 3'b001, 5,  pk(3'b000, 1, 1'b1)};
        vt[6] = '{3'b001, 3'b000, 1,  pk(3'b000, 0, 1'b1)};
        vt[7] = '{3'b001, 3'b000, 3,  pk(3'b000, 0, 1'b1)};
        vt[8] = '{3'b001, 3'b000, 1,  pk(3'b000, 0, 1'b0)};
        vt[9] = '{3'b001, 3'b000, 10, pk(3'b000, 0, 1'b0)};

        // clean issue on line 0
        do_reset();
        for (int v = 0; v < 10; v++) begin
            evt_raw = vt[v].evt;
            irq_wait = vt[v].wt;
            repeat (vt[v].cyc) tick();
            check($sformatf("vec%0d", v), dut_out, vt[v].exp);
        end

        // bounce rejection on line 1
        do_reset();
        rises = 0; pmax = 0;
        for (int i = 0; i < 80; i++) begin
            evt_raw[1] = (i >= 20) ? 1'b1 : ((i / 2) % 2 == 0);
            tick();
            if (ir[1] && !ir_prev[1]) rises++;
            if (int'(pend_cnt[PW +: PW]) > pmax) pmax = int'(pend_cnt[PW +: PW]);
        end
        check("bounce_rises", rises, 1);
        check("bounce_pend_max", pmax, 1);

        // queueing and saturation on line 2
        do_reset();
        for (int k = 0; k < 9; k++) begin
            evt_raw[2] = 1'b1; repeat (8) tick();
            evt_raw[2] = 1'b0; repeat (8) tick();
        end
        check("sat_pend", pend_cnt[2*PW +: PW], PMAX);
        check("sat_ovf", ovf[2], 1);
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            tick();
            found = ir[2] && !ir_prev[2];
        end
        per = 0; found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            tick();
            per++;
            found = ir[2] && !ir_prev[2];
        end
        check("repulse_period", per, PL + ATO);
        ovf_clr[2] = 1'b1; tick(); ovf_clr = '0;
        check("ovf_clr", ovf[2], 0);

        // increment coinciding with the acknowledge decrement on line 0
        do_reset();
        evt_raw[0] = 1'b1; repeat (8) tick();
        evt_raw[0] = 1'b0; repeat (8) tick();
        evt_raw[0] = 1'b1; repeat (10) tick();
        check("coinc_pend_pre", pend_cnt[0 +: PW], 2);
        irq_wait[0] = 1'b1; evt_raw[0] = 1'b0; repeat (10) tick();
        evt_raw[0] = 1'b1; repeat (6) tick();
        irq_wait[0] = 1'b0; tick();
        check("coinc_pend", pend_cnt[0 +: PW], 2);
        repeat (4) tick();
        check("coinc_gap_ir", ir[0], 0);
        tick();
        check("coinc_next_ir", ir[0], 1);

        // blocked line 1
        do_reset();
        evt_raw[1] = 1'b1; repeat (20) tick();
        irq_wait[1] = 1'b1;
        rises = 0;
        for (int i = 0; i < 500; i++) begin
            tick();
            if (ir[1] && !ir_prev[1]) rises++;
        end
        check("blocked_rises", rises, 0);
        check("blocked_pend", pend_cnt[PW +: PW], 1);
        irq_wait[1] = 1'b0; tick();
        check("blocked_dec", pend_cnt[PW +: PW], 0);
        repeat (4) tick();
        check("blocked_idle", busy, 0);

        // enable gating, then reset mid-pulse
        do_reset();
        for (int k = 0; k < 3; k++) begin
            evt_raw[0] = 1'b1; repeat (8) tick();
            evt_raw[0] = 1'b0; repeat (8) tick();
        end
        repeat (4) tick();
        en[0] = 1'b0; tick();
        check("en_pend", pend_cnt[0 +: PW], 3);
        rises = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (ir[0]) rises++;
        end
        check("en_off_pulses", rises, 0);
        en[0] = 1'b1; tick();
        check("en_resume_ir", ir[0], 1);
        check("en_resume_pend", pend_cnt[0 +: PW], 3);
        CLR = 1'b1;
        #1;
        check("async_clr_ir", ir, 0);
        check("async_clr_pend", pend_cnt, 0);
        model_reset();
        @(posedge clk);
        #1;
        CLR = 1'b0;

        // random run against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            for (int n = 0; n < 3; n++) begin
                if ($urandom_range(11) == 0) evt_raw[n] = ~evt_raw[n];
                if ($urandom_range(7) == 0) irq_wait[n] = ~irq_wait[n];
                if ($urandom_range(63) == 0) en[n] = ~en[n];
                ovf_clr[n] = ($urandom_range(31) == 0);
            end
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
